arm_instr_encoder: RTL and testbench
====================================

Name: arm_instr_encoder

Overview:
- Sequential ARM instruction encoder, the inverse of the control decoder.
- Accepts one instruction description per valid/ready handshake: class, funct, condition, registers, immediate.
- Builds the 32-bit machine word. DP immediates run through a multi-cycle rotate-immediate search.
- Emits the word with a word-aligned write address on an output valid/ready handshake. Used by the test-program loader to fill instruction memory.

Parameters:
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 0, out_addr value after reset.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept a request
- req_cond  in  4  condition field
- req_op  in  2  class: 00 DP, 01 mem, 10 branch, 11 illegal
- req_funct  in  6  DP {I,cmd[3:0],S}; mem {~I,P,U,B,W,L}; branch bit4 = link
- req_rn  in  4  first source / base register
- req_rd  in  4  destination register
- req_rm  in  4  register operand
- req_imm  in  32  DP: 32-bit value to encode; mem: bits[11:0]; branch: bits[23:0]
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address for out_instr
- out_err  out  1  word is not a faithful encoding of the request

Behaviour:
- Reset values: state IDLE, req_ready=1, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, rotation counter=0.
- Reset is asynchronous. Assertion in any state, including mid-search or while stalled, aborts immediately. The pending request is discarded and the address is not advanced.
- FSM states: IDLE, SEARCH, EMIT.
- IDLE: req_ready=1. On req_valid, all request fields are latched.
  - If req_op=00 and funct[5]=1, go to SEARCH with r=0.
  - Otherwise compute the word and go to EMIT.
- SEARCH: req_ready=0. Each cycle tests rotation index r (0..15), one per cycle.
  - Match when rol(imm, 2r)[31:8]==0.
  - On the first match, set the field to {r[3:0], rol(imm,2r)[7:0]} and go to EMIT.
  - If r=15 has no match, set the field to 12'h000, out_err=1, and go to EMIT.
  - Otherwise r increments.
- EMIT: out_valid=1. out_instr, out_addr and out_err stay stable until out_ready.
  - On out_valid&out_ready: out_addr += 4, wrapping modulo 2^ADDR_W; out_valid=0; out_err clears; go to IDLE.
  - req_ready stays 0 in EMIT, so there is no overlap of accept and emit.
- Latency, from accept edge to out_valid high:
  - 1 cycle for non-search requests.
  - 2+r cycles for a search matching at index r.
  - 17 cycles for a failed search.
- Encoding, common fields: [31:28]=cond, [27:26]=op.
- DP encoding:
  - [25:20]=funct, [19:16]=rn, [15:12]=rd.
  - [11:0] = rotated immediate if I=1, else {8'h00, rm}.
  - cmd=1101 (MOV) forces rn=0.
  - cmd=10xx (TST/TEQ/CMP/CMN) forces rd=0. These match the decoder's IgRn/NoWrite.
  - If cmd=10xx with S=0, the word is still encoded and out_err=1.
- Mem encoding:
  - [25:20]=funct, [19:16]=rn, [15:12]=rd.
  - [11:0] = imm[11:0] if funct[5]=0, else {8'h00, rm}.
- Branch encoding: [25]=1, [24]=funct[4], [23:0]=imm[23:0].
- op=11: out_instr=32'h0, out_err=1, emitted after 1 cycle; the address still advances on handshake.
- Request fields are sampled only on the accept edge. Later changes on req_* have no effect.

Test Plan:
1. ADD R1,R2,#5 (cond=E, op=00, funct=101000, rn=2, rd=1, imm=5) -> out_instr=0xE2821005, err=0, out_valid 2 cycles after accept, out_addr=0.
2. ADD R0,R0,#0x3F0 (imm=0x000003F0) -> match r=14, out_instr=0xE2800E3F, out_valid 16 cycles after accept; out_addr=4 when it is the second request.
3. Unencodable imm=0x00000101 on the same ADD -> out_instr=0xE2800000, out_err=1, out_valid 17 cycles after accept; next request emits with err=0.
4. LDR R3,[R4,#8] (op=01, funct=011001, rn=4, rd=3, imm=8) -> 0xE5943008, 1-cycle latency.
5. CMP R1,#0 with req_rd=7 (funct=110101) -> 0xE3510000 (rd forced 0). Then hold out_ready=0 for 3 cycles -> instr/addr stable, req_ready=0; on release out_addr +4.
6. Reset low during SEARCH (r=5) -> out_valid=0, req_ready=1, out_addr=BASE_ADDR immediately. After release, B with imm=0x000010 (funct=100000) -> 0xEA000010.

Source files
------------

// File: rtl/arm_instr_encoder_if.sv
// Request/response bundle between the instruction encoder and its producer/consumer.
// The encoder takes the slave modport; the test-program loader drives the master side.
interface arm_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_cond;
    logic [1:0]        req_op;
    logic [5:0]        req_funct;
    logic [3:0]        req_rn;
    logic [3:0]        req_rd;
    logic [3:0]        req_rm;
    logic [31:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output req_valid, req_cond, req_op, req_funct, req_rn, req_rd, req_rm, req_imm,
        output out_ready,
        input  req_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  req_valid, req_cond, req_op, req_funct, req_rn, req_rd, req_rm, req_imm,
        input  out_ready,
        output req_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/arm_instr_encoder.sv
// Sequential ARM instruction encoder: turns one instruction description into a
// 32-bit machine word plus a word-aligned write address for instruction memory.
module arm_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic                 clk,
    input logic                 reset,
    arm_instr_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, EMIT} state_t;

    state_t            state;
    logic [3:0]        cond_q;
    logic [5:0]        funct_q;
    logic [3:0]        rn_q;
    logic [3:0]        rd_q;
    logic [31:0]       imm_q;
    logic [3:0]        rot_q;
    logic              req_ready_q;
    logic              out_valid_q;
    logic              out_err_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] addr_q;

    logic [31:0]       rotated;
    logic              match;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] sh);
        logic [63:0] d;
        d = {x, x} << sh;
        return d[63:32];
    endfunction

    // Requests the decoder would not reproduce exactly: illegal class, or a
    // compare-class DP op without S (it would decode as a different instruction).
    function automatic logic bad_req(input logic [1:0] op, input logic [5:0] funct);
        return (op == 2'b11) || (op == 2'b00 && funct[4:3] == 2'b10 && !funct[0]);
    endfunction

    function automatic logic [31:0] encode(input logic [3:0] cond, input logic [1:0] op,
                                           input logic [5:0] funct, input logic [3:0] rn,
                                           input logic [3:0] rd, input logic [3:0] rm,
                                           input logic [31:0] imm, input logic [11:0] rot_field);
        logic [3:0]  rn_e;
        logic [3:0]  rd_e;
        logic [11:0] low;
        logic [31:0] word;
        rn_e = rn;
        rd_e = rd;
        low  = {8'h00, rm};
        word = 32'h0;
        case (op)
            2'b00: begin
                if (funct[4:1] == 4'b1101) rn_e = 4'h0;
                if (funct[4:3] == 2'b10)   rd_e = 4'h0;
                if (funct[5])              low  = rot_field;
                word = {cond, op, funct, rn_e, rd_e, low};
            end
            2'b01: begin
                if (!funct[5]) low = imm[11:0];
                word = {cond, op, funct, rn, rd, low};
            end
            2'b10:   word = {cond, 2'b10, 1'b1, funct[4], imm[23:0]};
            default: word = 32'h0;
        endcase
        return word;
    endfunction

    assign rotated = rol(imm_q, {rot_q, 1'b0});
    assign match   = (rotated[31:8] == 24'h0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            instr_q     <= 32'h0;
            addr_q      <= BASE_ADDR;
            rot_q       <= 4'h0;
            cond_q      <= 4'h0;
            funct_q     <= 6'h0;
            rn_q        <= 4'h0;
            rd_q        <= 4'h0;
            imm_q       <= 32'h0;
        end else begin
            case (state)
                // Accept: latch fields; immediate DP goes to the rotation search
                IDLE: begin
                    if (bus.req_valid) begin
                        cond_q      <= bus.req_cond;
                        funct_q     <= bus.req_funct;
                        rn_q        <= bus.req_rn;
                        rd_q        <= bus.req_rd;
                        imm_q       <= bus.req_imm;
                        rot_q       <= 4'h0;
                        req_ready_q <= 1'b0;
                        if (bus.req_op == 2'b00 && bus.req_funct[5]) begin
                            state <= SEARCH;
                        end else begin
                            instr_q     <= encode(bus.req_cond, bus.req_op, bus.req_funct,
                                                  bus.req_rn, bus.req_rd, bus.req_rm,
                                                  bus.req_imm, 12'h000);
                            out_err_q   <= bad_req(bus.req_op, bus.req_funct);
                            out_valid_q <= 1'b1;
                            state       <= EMIT;
                        end
                    end
                end
                // Search: one even rotation tested per cycle, first hit wins
                SEARCH: begin
                    if (match || rot_q == 4'hF) begin
                        instr_q     <= encode(cond_q, 2'b00, funct_q, rn_q, rd_q, 4'h0, imm_q,
                                              match ? {rot_q, rotated[7:0]} : 12'h000);
                        out_err_q   <= !match || bad_req(2'b00, funct_q);
                        out_valid_q <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        rot_q <= rot_q + 4'h1;
                    end
                end
                // Emit: hold word and address until the consumer takes them
                EMIT: begin
                    if (bus.out_ready) begin
                        addr_q      <= addr_q + ADDR_W'(4);
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_arm_instr_encoder.sv
// Directed, table-driven bench for arm_instr_encoder with hand-computed words.
module tb_arm_instr_encoder;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] exp_addr;

    arm_instr_encoder_if #(.ADDR_W(32)) bus ();

    arm_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic add(input string name, input logic [3:0] cond, input logic [1:0] op,
                       input logic [5:0] funct, input logic [3:0] rn, input logic [3:0] rd,
                       input logic [3:0] rm, input logic [31:0] imm,
                       input logic [31:0] exp_instr, input logic exp_err, input int exp_lat);
        vec_t v;
        v.name = name; v.cond = cond; v.op = op; v.funct = funct;
        v.rn = rn; v.rd = rd; v.rm = rm; v.imm = imm;
        v.exp_instr = exp_instr; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge with the DUT idle; leaves out_ready low.
    task automatic issue(input vec_t v, output int lat);
        bus.req_cond  = v.cond;
        bus.req_op    = v.op;
        bus.req_funct = v.funct;
        bus.req_rn    = v.rn;
        bus.req_rd    = v.rd;
        bus.req_rm    = v.rm;
        bus.req_imm   = v.imm;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_cond  = 4'($urandom);
        bus.req_op    = 2'($urandom);
        bus.req_funct = 6'($urandom);
        bus.req_rn    = 4'($urandom);
        bus.req_rd    = 4'($urandom);
        bus.req_rm    = 4'($urandom);
        bus.req_imm   = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_handshake(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_addr += 32'd4;
        check({name, " valid_after"}, 32'(bus.out_valid), 32'd0);
        check({name, " ready_after"}, 32'(bus.req_ready), 32'd1);
        check({name, " addr_after"}, bus.out_addr, exp_addr);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v, lat);
        check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({v.name, " instr"}, bus.out_instr, v.exp_instr);
        check({v.name, " err"}, 32'(bus.out_err), 32'(v.exp_err));
        check({v.name, " addr"}, bus.out_addr, exp_addr);
        check({v.name, " ready_in_emit"}, 32'(bus.req_ready), 32'd0);
        finish_handshake(v.name);
    endtask

    initial begin
        vec_t v;
        int   lat;
        checks = 0; failures = 0; exp_addr = 32'h0;
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_cond = 4'h0; bus.req_op = 2'b00; bus.req_funct = 6'h0;
        bus.req_rn = 4'h0; bus.req_rd = 4'h0; bus.req_rm = 4'h0; bus.req_imm = 32'h0;
        bus.out_ready = 1'b0;

        #12;
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_instr", bus.out_instr, 32'h0);
        check("rst out_err", 32'(bus.out_err), 32'd0);
        check("rst out_addr", bus.out_addr, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        add("add_imm5",   4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 4'd0, 32'h0000_0005, 32'hE282_1005, 1'b0, 2);
        add("add_3f0",    4'hE, 2'b00, 6'b101000, 4'd0, 4'd0, 4'd0, 32'h0000_03F0, 32'hE280_0E3F, 1'b0, 16);
        add("add_unenc",  4'hE, 2'b00, 6'b101000, 4'd0, 4'd0, 4'd0, 32'h0000_0101, 32'hE280_0000, 1'b1, 17);
        add("add_again",  4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 4'd0, 32'h0000_0005, 32'hE282_1005, 1'b0, 2);
        add("ldr_imm8",   4'hE, 2'b01, 6'b011001, 4'd4, 4'd3, 4'd0, 32'h0000_0008, 32'hE594_3008, 1'b0, 1);
        add("branch",     4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 4'd0, 32'h0000_0010, 32'hEA00_0010, 1'b0, 1);
        add("illegal",    4'hE, 2'b11, 6'b111111, 4'd1, 4'd2, 4'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
        add("mov_reg",    4'hE, 2'b00, 6'b011010, 4'd5, 4'd2, 4'd3, 32'h0000_0000, 32'hE1A0_2003, 1'b0, 1);
        add("cmp_no_s",   4'hE, 2'b00, 6'b010100, 4'd1, 4'd7, 4'd2, 32'h0000_0000, 32'hE141_0002, 1'b1, 1);
        add("str_reg",    4'hE, 2'b01, 6'b111000, 4'd4, 4'd3, 4'd5, 32'h0000_0FFF, 32'hE784_3005, 1'b0, 1);
        add("bl",         4'h0, 2'b10, 6'b110000, 4'd0, 4'd0, 4'd0, 32'hAB12_3456, 32'h0B12_3456, 1'b0, 1);
        add("mov_ff000000", 4'hE, 2'b00, 6'b111010, 4'd9, 4'd4, 4'd0, 32'hFF00_0000, 32'hE3A0_44FF, 1'b0, 6);
        add("add_wrap_rot", 4'hE, 2'b00, 6'b101000, 4'd0, 4'd0, 4'd0, 32'hC000_003F, 32'hE280_01FF, 1'b0, 3);
        add("add_ff",     4'hE, 2'b00, 6'b101000, 4'd0, 4'd0, 4'd0, 32'h0000_00FF, 32'hE280_00FF, 1'b0, 2);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // CMP with rd forced to zero, consumer stalls for three cycles
        v.name = "cmp_stall"; v.cond = 4'hE; v.op = 2'b00; v.funct = 6'b110101;
        v.rn = 4'd1; v.rd = 4'd7; v.rm = 4'd0; v.imm = 32'h0;
        issue(v, lat);
        check("cmp_stall latency", 32'(lat), 32'd2);
        for (int c = 0; c < 3; c++) begin
            check("cmp_stall instr", bus.out_instr, 32'hE351_0000);
            check("cmp_stall addr", bus.out_addr, exp_addr);
            check("cmp_stall valid", 32'(bus.out_valid), 32'd1);
            check("cmp_stall req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        finish_handshake("cmp_stall");

        // Reset in the middle of a search at rotation index 5
        v.name = "rst_search"; v.funct = 6'b101000; v.rn = 4'd0; v.rd = 4'd0; v.imm = 32'h0000_0101;
        bus.req_cond = v.cond; bus.req_op = v.op; bus.req_funct = v.funct;
        bus.req_rn = v.rn; bus.req_rd = v.rd; bus.req_rm = v.rm; bus.req_imm = v.imm;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("rst_search before valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_search out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_search req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_search out_addr", bus.out_addr, 32'h0);
        check("rst_search out_err", 32'(bus.out_err), 32'd0);
        #1;
        reset = 1'b1;
        exp_addr = 32'h0;
        @(posedge clk); #1;

        v.name = "b_after_rst"; v.cond = 4'hE; v.op = 2'b10; v.funct = 6'b100000;
        v.imm = 32'h0000_0010; v.exp_instr = 32'hEA00_0010; v.exp_err = 1'b0; v.exp_lat = 1;
        run_vec(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
